// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory-port arbiter.
// Optional round-robin arbitration is selected with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 64;
    localparam int DATA_W_DEF      = 64;
    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int TMO_W           = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Loadable down-counter that bounds one memory transaction.
// o_expired is high whenever the count sits at zero.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int CNT_W = TMO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ce memory port between the fetch and data ports of the core.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_ce,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              bus_err
);

    // Counter is loaded with one less than the limit so BUSY lasts exactly TIMEOUT_CYC cycles.
    localparam logic [TMO_W-1:0] L_TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    arb_state_t        r_state;
    owner_t            r_owner;
    logic              r_half;
    logic              r_err;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cap;

    logic w_start;
    logic w_grant_d;
    logic w_grant_if;
    logic w_expired;
    logic w_resp;
    logic w_unused;

    assign w_start = (r_state == IDLE) && (if_req || d_req);

`ifdef MEM_ARB_RR_EN
    owner_t r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= OWN_IF;
        end else if (w_start) begin
            r_last <= w_grant_d ? OWN_D : OWN_IF;
        end
    end

    assign w_grant_d = d_req && (!if_req || (r_last == OWN_IF));
`else
    assign w_grant_d = d_req;
`endif

    assign w_grant_if = if_req && !w_grant_d;

    mem_arb_timeout #(
        .CNT_W (TMO_W)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_clear    ((r_state != BUSY) && !w_start),
        .i_load     (w_start),
        .i_load_val (L_TMO_LOAD),
        .i_en       (r_state == BUSY),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_half      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cap       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_owner     <= OWN_D;
                        r_half      <= 1'b0;
                        r_mem_rw    <= d_rw;
                        r_mem_addr  <= {d_addr[ADDR_W-1:3], 3'b000};
                        r_mem_wdata <= d_wdata;
                        r_state     <= BUSY;
                    end else if (w_grant_if) begin
                        r_owner     <= OWN_IF;
                        r_half      <= if_addr[2];
                        r_mem_rw    <= 1'b0;
                        r_mem_addr  <= {if_addr[ADDR_W-1:3], 3'b000};
                        r_mem_wdata <= '0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    // A completion on the expiry cycle still counts as success.
                    if (mem_valid) begin
                        r_cap   <= mem_rdata;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (w_expired) begin
                        r_cap   <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_resp    = (r_state == RESP);
    assign mem_ce    = (r_state == BUSY);
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_valid  = w_resp && (r_owner == OWN_IF);
    assign d_valid   = w_resp && (r_owner == OWN_D);
    assign if_data   = if_valid ? (r_half ? r_cap[63:32] : r_cap[31:0]) : 32'h0;
    assign d_rdata   = (d_valid && !r_mem_rw) ? r_cap : '0;
    assign bus_err   = w_resp && r_err;

    assign w_unused = ^{if_addr[1:0], d_addr[2:0]};

endmodule
